dac_spi_slave_model: RTL and testbench
======================================

# dac_spi_slave_model

Parametrised, synthesizable behavioural model of a multi-channel 24-bit-frame SPI DAC (DACx0504 family and its wider and narrower variants), used in simulation benches as the target of the FPGA's DAC SPI master. Unlike a read-only echo model, it supports register writes, per-channel synchronous (trigger-latched) update, broadcast writes, soft reset, configurable data resolution, and framing-error detection. Committed DAC codes are exported for scoreboard checking.

## Interface
- NUM_CH, 4, number of DAC channels (1..8); channel n lives at address 8+n
- DATA_W, 16, DAC resolution (12, 14 or 16); codes are left-justified in the 16-bit data field
- DEVICE_ID, 16'hABCD, read-only value returned at address 1
- SYS_RST  in  1  reset, asynchronous, active-high
- DAC_CLK  in  1  SPI clock, free-running; all logic on rising edge
- DAC_CS_N  in  1  chip select, active-low, sampled on DAC_CLK
- DAC_SDI  in  1  serial data in, MSB first
- DAC_SDO  out  1  serial data out, MSB first
- DAC_CODE  out  16*NUM_CH  active output codes; channel n at [16n+15:16n]
- DAC_UPDATE  out  NUM_CH  one-cycle pulse per channel whose DAC_CODE changed value source (written or triggered)
- FRAME_ERR  out  1  one-cycle pulse on an aborted frame

## Operation
- Frame: 24 bits. Bit 23 is R/W (1 = read), bits 22:20 are ignored, bits 19:16 are the address, bits 15:0 are the data.
- Shift-in: on each rising edge with CS_N low, shift_in <= {shift_in[22:0], SDI}. bit_cnt increments and saturates at 31.
- Commit: on the first rising edge with CS_N high, if bit_cnt == 24, the frame is decoded. bit_cnt then clears. Idle edges with CS_N high do nothing else.
- Abort: on CS_N high with bit_cnt not 0 and not 24, there is no decode. FRAME_ERR pulses and STATUS[0] is set (sticky).
- Registers:
  - 0 NOP: writes ignored, reads 0.
  - 1 DEVICE_ID: read-only.
  - 2 SYNC: RW, reset 0. Bit n set means channel n is synchronous.
  - 3 CONFIG: RW, reset 0. Storage only.
  - 4 GAIN: RW, reset 16'h0001. Storage only.
  - 5 TRIGGER: write-only, reads 0.
    - data[3:0] == 4'b1010: soft reset. Every register returns to reset value, and DAC_CODE and buffers clear to 0. No DAC_UPDATE.
    - data[4] = 1 (LDAC): every synchronous channel copies buffer to DAC_CODE.
    - Soft reset has priority over LDAC.
  - 6 BRDCAST: write loads the masked data into all channel buffers. Asynchronous channels also update DAC_CODE. Reads return the last written value.
  - 7 STATUS: bit0 is the sticky frame error. Read-clear: the value is captured into the response, then bit0 clears.
  - 8+n DACn: the write loads the buffer. If SYNC[n] = 0, DAC_CODE[n] also updates at the same edge. Reads return the buffer.
- Data mask: bits [15-DATA_W:0] of DAC data are forced to 0 on write and readback.
- Addresses at or above 8+NUM_CH: writes ignored, reads 0.
- Read: at commit, shift_out <= {1'b1, 3'b000, addr, value}. The response appears on the next frame.
- Write: at commit, shift_out <= 0, so the next frame returns zeros.
- Shift-out: on each rising edge with CS_N low, shift_out <= {shift_out[22:0], 1'b0}. DAC_SDO = shift_out[23] combinationally, so bit 23 is valid before the first edge of the next frame.
- Abort frame: shift_out <= 0.

## Timing
- Reset (asynchronous):
  - Outputs: DAC_SDO = 0, DAC_CODE = 0, DAC_UPDATE = 0, FRAME_ERR = 0.
  - State: bit_cnt = 0, shift registers = 0.
  - Registers: all take their reset values.
- Reset asserted mid-frame discards the frame. The first frame after reset release must start from bit_cnt = 0.
- Commit latency: DAC_CODE, DAC_UPDATE, FRAME_ERR and the register state change at the CS_N-high edge, i.e. 1 DAC_CLK after the 24th data edge. The host must give at least one CS_N-high edge between frames.
- DAC_UPDATE and FRAME_ERR are high for exactly one DAC_CLK.
- Writing the same value to a channel still pulses DAC_UPDATE.
- LDAC with no synchronous channels produces no pulse.
- Back-to-back frames separated by one CS_N-high edge are supported.

## Test plan
- Reset, then read DEVICE_ID followed by a NOP frame -> second frame SDO = 24'h81ABCD. DAC_CODE = 0 throughout.
- NUM_CH = 4, DATA_W = 12: write DAC2 = 16'h5A5F -> DAC_CODE[2] = 16'h5A50 and a single DAC_UPDATE[2] pulse at commit. Readback of DAC2 returns 24'h8A5A50.
- Set SYNC = 16'h0003, write DAC0 = 16'h1111 and DAC1 = 16'h2222 -> codes unchanged. TRIGGER = 16'h0010 -> both codes update on the same edge and DAC_UPDATE = 4'b0011.
- BRDCAST = 16'hFFFF with SYNC = 16'h0001 -> channels 1-3 show 16'hFFF0 at once, channel 0 does not. LDAC updates channel 0.
- Frame of 20 bits, then CS_N high -> FRAME_ERR pulse, no register change. STATUS read returns bit0 = 1, and a second STATUS read returns 0.
- Write to address 15 with NUM_CH = 4 -> no change, read returns 24'h8F0000. Then TRIGGER = 16'h000A -> all codes 0, GAIN reads 16'h0001, no DAC_UPDATE.

Source files
------------

// File: rtl/dac_spi_slave_model.sv
// Behavioural, synthesizable model of a 24-bit-frame multi-channel SPI DAC.
// Frames commit on the first CS_N-high edge; DAC codes are exported for checking.
module dac_spi_slave_model #(
  parameter int          NUM_CH    = 4,
  parameter int          DATA_W    = 16,
  parameter logic [15:0] DEVICE_ID = 16'hABCD
) (
  input  logic                   SYS_RST,
  input  logic                   DAC_CLK,
  input  logic                   DAC_CS_N,
  input  logic                   DAC_SDI,
  output logic                   DAC_SDO,
  output logic [16*NUM_CH-1:0]   DAC_CODE,
  output logic [NUM_CH-1:0]      DAC_UPDATE,
  output logic                   FRAME_ERR
);

  localparam logic [15:0] DATA_MASK = 16'hFFFF << (16 - DATA_W);
  localparam logic [15:0] GAIN_RST  = 16'h0001;

  localparam logic [3:0] ADDR_ID     = 4'd1;
  localparam logic [3:0] ADDR_SYNC   = 4'd2;
  localparam logic [3:0] ADDR_CONFIG = 4'd3;
  localparam logic [3:0] ADDR_GAIN   = 4'd4;
  localparam logic [3:0] ADDR_TRIG   = 4'd5;
  localparam logic [3:0] ADDR_BCAST  = 4'd6;
  localparam logic [3:0] ADDR_STATUS = 4'd7;

  logic [23:0]       shift_in_q, shift_in_d;
  logic [23:0]       shift_out_q, shift_out_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [15:0]       sync_q, sync_d;
  logic [15:0]       config_q, config_d;
  logic [15:0]       gain_q, gain_d;
  logic [15:0]       brdcast_q, brdcast_d;
  logic              status_err_q, status_err_d;
  logic [15:0]       chbuf_q [NUM_CH];
  logic [15:0]       chbuf_d [NUM_CH];
  logic [15:0]       code_q  [NUM_CH];
  logic [15:0]       code_d  [NUM_CH];
  logic [NUM_CH-1:0] update_q, update_d;
  logic              frame_err_q, frame_err_d;

  logic              frm_rd;
  logic [3:0]        frm_addr;
  logic [15:0]       frm_data;
  logic [15:0]       frm_data_masked;
  logic [15:0]       rd_value;
  logic              unused_bits;

  assign frm_rd          = shift_in_q[23];
  assign frm_addr        = shift_in_q[19:16];
  assign frm_data        = shift_in_q[15:0];
  assign frm_data_masked = frm_data & DATA_MASK;
  assign unused_bits     = ^shift_in_q[22:20];

  always_comb begin
    rd_value = '0;
    case (frm_addr)
      ADDR_ID:     rd_value = DEVICE_ID;
      ADDR_SYNC:   rd_value = sync_q;
      ADDR_CONFIG: rd_value = config_q;
      ADDR_GAIN:   rd_value = gain_q;
      ADDR_BCAST:  rd_value = brdcast_q;
      ADDR_STATUS: rd_value = {15'd0, status_err_q};
      default: begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (frm_addr == 4'(8 + n)) rd_value = chbuf_q[n];
        end
      end
    endcase
  end

  always_comb begin
    shift_in_d   = shift_in_q;
    shift_out_d  = shift_out_q;
    bit_cnt_d    = bit_cnt_q;
    sync_d       = sync_q;
    config_d     = config_q;
    gain_d       = gain_q;
    brdcast_d    = brdcast_q;
    status_err_d = status_err_q;
    chbuf_d      = chbuf_q;
    code_d       = code_q;
    update_d     = '0;
    frame_err_d  = 1'b0;

    if (!DAC_CS_N) begin
      shift_in_d  = {shift_in_q[22:0], DAC_SDI};
      shift_out_d = {shift_out_q[22:0], 1'b0};
      bit_cnt_d   = (bit_cnt_q == 5'd31) ? bit_cnt_q : bit_cnt_q + 5'd1;
    end else if (bit_cnt_q == 5'd24) begin
      bit_cnt_d = '0;
      if (frm_rd) begin
        shift_out_d = {1'b1, 3'b000, frm_addr, rd_value};
        // STATUS is read-clear: value above already captured the old bit
        if (frm_addr == ADDR_STATUS) status_err_d = 1'b0;
      end else begin
        shift_out_d = '0;
        case (frm_addr)
          ADDR_SYNC:   sync_d   = frm_data;
          ADDR_CONFIG: config_d = frm_data;
          ADDR_GAIN:   gain_d   = frm_data;
          ADDR_TRIG: begin
            if (frm_data[3:0] == 4'b1010) begin
              sync_d       = '0;
              config_d     = '0;
              gain_d       = GAIN_RST;
              brdcast_d    = '0;
              status_err_d = 1'b0;
              for (int n = 0; n < NUM_CH; n++) begin
                chbuf_d[n] = '0;
                code_d[n]  = '0;
              end
            end else if (frm_data[4]) begin
              for (int n = 0; n < NUM_CH; n++) begin
                if (sync_q[n]) begin
                  code_d[n]   = chbuf_q[n];
                  update_d[n] = 1'b1;
                end
              end
            end
          end
          ADDR_BCAST: begin
            brdcast_d = frm_data;
            for (int n = 0; n < NUM_CH; n++) begin
              chbuf_d[n] = frm_data_masked;
              if (!sync_q[n]) begin
                code_d[n]   = frm_data_masked;
                update_d[n] = 1'b1;
              end
            end
          end
          default: begin
            for (int n = 0; n < NUM_CH; n++) begin
              if (frm_addr == 4'(8 + n)) begin
                chbuf_d[n] = frm_data_masked;
                if (!sync_q[n]) begin
                  code_d[n]   = frm_data_masked;
                  update_d[n] = 1'b1;
                end
              end
            end
          end
        endcase
      end
    end else if (bit_cnt_q != 5'd0) begin
      // Short or overlong frame: drop it and flag the error
      bit_cnt_d    = '0;
      shift_out_d  = '0;
      frame_err_d  = 1'b1;
      status_err_d = 1'b1;
    end
  end

  always_ff @(posedge DAC_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      shift_in_q   <= '0;
      shift_out_q  <= '0;
      bit_cnt_q    <= '0;
      sync_q       <= '0;
      config_q     <= '0;
      gain_q       <= GAIN_RST;
      brdcast_q    <= '0;
      status_err_q <= 1'b0;
      update_q     <= '0;
      frame_err_q  <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        chbuf_q[n] <= '0;
        code_q[n]  <= '0;
      end
    end else begin
      shift_in_q   <= shift_in_d;
      shift_out_q  <= shift_out_d;
      bit_cnt_q    <= bit_cnt_d;
      sync_q       <= sync_d;
      config_q     <= config_d;
      gain_q       <= gain_d;
      brdcast_q    <= brdcast_d;
      status_err_q <= status_err_d;
      update_q     <= update_d;
      frame_err_q  <= frame_err_d;
      for (int n = 0; n < NUM_CH; n++) begin
        chbuf_q[n] <= chbuf_d[n];
        code_q[n]  <= code_d[n];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_code
      assign DAC_CODE[16*gi +: 16] = code_q[gi];
    end
  endgenerate

  assign DAC_SDO    = shift_out_q[23];
  assign DAC_UPDATE = update_q;
  assign FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_dac_spi_slave_model.sv
// Directed bench for dac_spi_slave_model (4 channels, 12-bit data): SDO responses
// are checked through a scoreboard queue, codes and pulses against constants.
module tb_dac_spi_slave_model;

  logic        clk;
  logic        rst;
  logic        cs_n;
  logic        sdi;
  logic        sdo;
  logic [63:0] code;
  logic [3:0]  upd;
  logic        ferr;

  int n_pass  = 0;
  int n_total = 0;
  logic [23:0] exp_q [$];

  dac_spi_slave_model #(
    .NUM_CH    (4),
    .DATA_W    (12),
    .DEVICE_ID (16'hABCD)
  ) dut (
    .SYS_RST    (rst),
    .DAC_CLK    (clk),
    .DAC_CS_N   (cs_n),
    .DAC_SDI    (sdi),
    .DAC_SDO    (sdo),
    .DAC_CODE   (code),
    .DAC_UPDATE (upd),
    .FRAME_ERR  (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drives nbits of tx, collects SDO in the same bit positions, then one CS_N-high edge.
  task automatic frame(input logic [23:0] tx, input int nbits, output logic [23:0] rx);
    int idx;
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = 23 - i;
      @(negedge clk);
      cs_n = 1'b0;
      sdi  = tx[idx];
      #1;
      rx[idx] = sdo;
    end
    @(negedge clk);
    cs_n = 1'b1;
    sdi  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input string tag, input logic [23:0] tx, input int nbits,
                      input logic [23:0] next_rsp);
    logic [23:0] rx;
    logic [23:0] exp;
    logic [23:0] m;
    frame(tx, nbits, rx);
    m = 24'hFFFFFF << (24 - nbits);
    if (exp_q.size() == 0) begin
      n_total++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      exp = exp_q.pop_front();
      chk(tag, 64'(rx), 64'(exp & m));
    end
    exp_q.push_back(next_rsp);
    $display("frame %s tx=%h bits=%0d rx=%h code=%h upd=%b ferr=%b",
             tag, tx, nbits, rx, code, upd, ferr);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    cs_n = 1'b1;
    sdi  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sdo",  64'(sdo),  64'h0);
    chk("rst_code", code,      64'h0);
    chk("rst_upd",  64'(upd),  64'h0);
    chk("rst_ferr", 64'(ferr), 64'h0);
    rst = 1'b0;
    exp_q.push_back(24'h0);

    xfer("rd_id", 24'h810000, 24, 24'h81ABCD);
    chk("id_code", code, 64'h0);
    xfer("nop", 24'h000000, 24, 24'h0);
    chk("nop_code", code, 64'h0);

    xfer("wr_dac2", 24'h0A5A5F, 24, 24'h0);
    chk("dac2_code", code, {16'h0000, 16'h5A50, 16'h0000, 16'h0000});
    chk("dac2_upd", 64'(upd), 64'h4);
    next_cycle();
    chk("dac2_upd_end", 64'(upd), 64'h0);
    xfer("wr_dac2_same", 24'h0A5A5A, 24, 24'h0);
    chk("dac2_same_upd", 64'(upd), 64'h4);
    xfer("rd_dac2", 24'h8A0000, 24, 24'h8A5A50);

    xfer("wr_sync3", 24'h020003, 24, 24'h0);
    xfer("wr_dac0", 24'h081111, 24, 24'h0);
    chk("dac0_held", code, {16'h0000, 16'h5A50, 16'h0000, 16'h0000});
    chk("dac0_upd", 64'(upd), 64'h0);
    xfer("wr_dac1", 24'h092222, 24, 24'h0);
    chk("dac1_held", code, {16'h0000, 16'h5A50, 16'h0000, 16'h0000});
    xfer("ldac", 24'h050010, 24, 24'h0);
    chk("ldac_code", code, {16'h0000, 16'h5A50, 16'h2220, 16'h1110});
    chk("ldac_upd", 64'(upd), 64'h3);
    next_cycle();
    chk("ldac_upd_end", 64'(upd), 64'h0);

    xfer("wr_sync1", 24'h020001, 24, 24'h0);
    xfer("bcast", 24'h06FFFF, 24, 24'h0);
    chk("bcast_code", code, {16'hFFF0, 16'hFFF0, 16'hFFF0, 16'h1110});
    chk("bcast_upd", 64'(upd), 64'hE);
    xfer("ldac0", 24'h050010, 24, 24'h0);
    chk("ldac0_code", code, {16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0});
    chk("ldac0_upd", 64'(upd), 64'h1);

    xfer("abort20", 24'h0B1234, 20, 24'h0);
    chk("abort_ferr", 64'(ferr), 64'h1);
    chk("abort_upd", 64'(upd), 64'h0);
    chk("abort_code", code, {16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0});
    next_cycle();
    chk("abort_ferr_end", 64'(ferr), 64'h0);
    xfer("rd_status1", 24'h870000, 24, 24'h870001);
    xfer("rd_status2", 24'h870000, 24, 24'h870000);

    xfer("wr_a15", 24'h0F1234, 24, 24'h0);
    chk("a15_code", code, {16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0});
    chk("a15_upd", 64'(upd), 64'h0);
    xfer("rd_a15", 24'h8F0000, 24, 24'h8F0000);
    xfer("soft_rst", 24'h05000A, 24, 24'h0);
    chk("srst_code", code, 64'h0);
    chk("srst_upd", 64'(upd), 64'h0);
    xfer("rd_gain", 24'h840000, 24, 24'h840001);
    xfer("rd_sync", 24'h820000, 24, 24'h820000);
    xfer("rd_dac1", 24'h890000, 24, 24'h890000);

    xfer("wr_dac3", 24'h0B1234, 24, 24'h0);
    chk("dac3_code", code, {16'h1230, 16'h0000, 16'h0000, 16'h0000});
    chk("dac3_upd", 64'(upd), 64'h8);
    xfer("ldac_none", 24'h050010, 24, 24'h0);
    chk("ldac_none_upd", 64'(upd), 64'h0);
    chk("ldac_none_code", code, {16'h1230, 16'h0000, 16'h0000, 16'h0000});

    // Reset in the middle of a frame, applied between clock edges
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cs_n = 1'b0;
      sdi  = 1'b1;
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_code", code, 64'h0);
    chk("async_rst_sdo", 64'(sdo), 64'h0);
    cs_n = 1'b1;
    sdi  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(24'h0);
    xfer("rd_id_post", 24'h810000, 24, 24'h81ABCD);
    chk("post_ferr", 64'(ferr), 64'h0);
    xfer("nop_post", 24'h000000, 24, 24'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
